// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared types and constants for the serial instruction-memory
//               boot loader (loader FSM states, receiver states, image format).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_loader_pkg;

    // Loader FSM. CHECK is only reachable when the checksum option is built in.
    typedef enum logic [2:0] {
        ST_CNT_LO = 3'd0,
        ST_CNT_HI = 3'd1,
        ST_LOAD   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_RUN    = 3'd4,
        ST_ERR    = 3'd5
    } loader_state_t;

    // UART receiver frame states.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Image header: little-endian 16-bit word count.
    localparam int unsigned HDR_BYTES            = 2;
    // Payload words are sent as four little-endian bytes.
    localparam int unsigned BYTES_PER_WORD       = 4;
    // 50 MHz system clock, 115200 baud.
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

endpackage

`default_nettype wire

// File: rtl/imem_loader_uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver. Two-flop synchronizer, start-bit glitch
//               rejection at half a bit, centre sampling of data and stop
//               bits. Emits a one-cycle byte_valid_o or frame_err_o per frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
    import imem_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] c_HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] c_FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic          sync1_q, sync2_q, prev_q;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    // Synchronize rx and keep the previous synchronized level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Frame state, sample timer, bit counter and output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state: each sample point is one full bit after the previous one,
    // the first being half a bit after the falling edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == c_HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // A start bit that is high again at its centre was a glitch.
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == c_FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == c_FULL_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = sync2_q;
                    ferr_d  = !sync2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_o       = shift_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = ferr_q;

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : UART boot loader. Receives a word count and a little-endian
//               program image, writes it into instruction memory one word at
//               a time, and holds the core in reset until the image is
//               complete. Protocol errors park the loader in ERR.
//               Optional trailing XOR checksum: define IMEM_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DEPTH        = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx,
    output logic                     imem_we,
    output logic [$clog2(DEPTH)-1:0] imem_waddr,
    output logic [31:0]              imem_wdata,
    output logic                     cpu_reset,
    output logic                     done,
    output logic                     error,
    output logic [15:0]              loaded_words
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [15:0]   c_DEPTH16    = 16'(DEPTH);
    localparam logic [AW-1:0] c_LAST_ADDR  = AW'(DEPTH - 1);
    localparam logic [1:0]    c_LAST_BYTE  = 2'(BYTES_PER_WORD - 1);

    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_ferr;

    loader_state_t state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [23:0]   shift_q, shift_d;
    logic [1:0]    idx_q, idx_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [15:0]   loaded_q, loaded_d;
    logic [15:0]   w_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .rst_n        (reset),
        .rx_i         (rx),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_err_o  (rx_ferr)
    );

    // Full word count as it becomes known on the high count byte.
    assign w_count = {rx_byte, cnt_q[7:0]};

    // Loader state and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_CNT_LO;
            cnt_q    <= '0;
            shift_q  <= '0;
            idx_q    <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            loaded_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            loaded_q <= loaded_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    // Next-state: header decode, word assembly, write strobe and bookkeeping.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        loaded_d = loaded_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d   = csum_q;
`endif

        // Address/count advance in the cycle after the strobe; the address
        // holds at the last location rather than wrapping.
        if (we_q) begin
            loaded_d = loaded_q + 16'd1;
            if (waddr_q != c_LAST_ADDR) begin
                waddr_d = waddr_q + 1'b1;
            end
        end

        unique case (state_q)
            ST_CNT_LO: begin
                if (rx_valid) begin
                    cnt_d[7:0] = rx_byte;
                    state_d    = ST_CNT_HI;
                end
            end
            ST_CNT_HI: begin
                if (rx_valid) begin
                    cnt_d[15:8] = rx_byte;
                    // Oversized counts are rejected before any write happens.
                    if ((w_count != 16'd0) && (w_count <= c_DEPTH16)) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_LOAD: begin
                if (rx_valid) begin
                    shift_d = {rx_byte, shift_q[23:8]};
                    idx_d   = idx_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ rx_byte;
`endif
                    if (idx_q == c_LAST_BYTE) begin
                        we_d    = 1'b1;
                        wdata_d = {rx_byte, shift_q};
                    end
                end
                if (we_q && ((loaded_q + 16'd1) == cnt_q)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_RUN;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (rx_valid) begin
                    state_d = (rx_byte == csum_q) ? ST_RUN : ST_ERR;
                end
            end
`endif
            ST_RUN: begin
                state_d = ST_RUN;
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: state_d = ST_ERR;
        endcase

        // A broken frame aborts everything except a completed load.
        if (rx_ferr && (state_q != ST_RUN)) begin
            state_d = ST_ERR;
            we_d    = 1'b0;
        end
    end

    assign imem_we      = we_q;
    assign imem_waddr   = waddr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_reset    = (state_q != ST_RUN);
    assign done         = (state_q == ST_RUN);
    assign error        = (state_q == ST_ERR);
    assign loaded_words = loaded_q;

endmodule

`default_nettype wire
